mem_port_arbiter: RTL and testbench

Sequences the single external memory port between the data-side requester (dcache miss/write-through or uncached data access) and the instruction-side requester (icache refill or uncached fetch). It replaces ad-hoc state-based muxing with a registered request/grant/ack handshake, dmem-first priority with a bounded starvation guard for imem, and a per-transaction timeout. It sits between the two caches and the external memory pins.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_timeout_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the external memory port arbiter: FSM state encoding
// and requester IDs, kept here so later requesters (DMA, debug) can reuse them.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DMEM = 2'd1;
    localparam logic [1:0] ST_IMEM = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        DMEM = ST_DMEM,
        IMEM = ST_IMEM
    } arb_state_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_DMEM = 2'd0;
    localparam req_id_t REQ_IMEM = 2'd1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating busy-cycle counter with synchronous clear; term flags that the
// next enabled increment would reach MAX.
module mem_timeout_counter #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] LAST = W'(MAX - 1);
    localparam logic [W-1:0] TOP  = W'(MAX);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (en && count != TOP) begin
            count <= count + W'(1);
        end
    end

    assign term = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between dmem and imem requesters
// with dmem-first priority, an imem starvation guard and a per-transaction timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dmem_req,
    input  logic                 dmem_wr,
    input  logic [31:0]          dmem_addr,
    input  logic [WORD_SIZE-1:0] dmem_wdata,
    output logic                 dmem_gnt,
    output logic                 dmem_ack,
    input  logic                 imem_req,
    input  logic [31:0]          imem_addr,
    output logic                 imem_gnt,
    output logic                 imem_ack,
    output logic                 err,
    output logic [WORD_SIZE-1:0] rdata,
    output logic [31:0]          mem_addr,
    output logic [WORD_SIZE-1:0] data_in,
    output logic                 en_ext_mem_re,
    output logic                 en_ext_mem_wr,
    input  logic [WORD_SIZE-1:0] data_out,
    input  logic                 mem_ready
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state;
    req_id_t             owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic                busy;
    logic                tmo_term;
    logic                imem_turn;

    assign busy = (state != IDLE);

    // imem wins only when dmem is absent or has used up its streak
    assign imem_turn = imem_req && (!dmem_req || starve_cnt == STARVE_MAX);

    mem_timeout_counter #(
        .MAX (TIMEOUT)
    ) u_tmo (
        .clk  (clk),
        .rst  (rst),
        .clr  (!busy),
        .en   (busy && !mem_ready),
        .term (tmo_term)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            owner         <= REQ_DMEM;
            starve_cnt    <= '0;
            dmem_gnt      <= 1'b0;
            dmem_ack      <= 1'b0;
            imem_gnt      <= 1'b0;
            imem_ack      <= 1'b0;
            err           <= 1'b0;
            rdata         <= '0;
            mem_addr      <= '0;
            data_in       <= '0;
            en_ext_mem_re <= 1'b0;
            en_ext_mem_wr <= 1'b0;
        end else begin
            dmem_ack <= 1'b0;
            imem_ack <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmem_req && !imem_turn) begin
                        state         <= DMEM;
                        owner         <= REQ_DMEM;
                        dmem_gnt      <= 1'b1;
                        mem_addr      <= dmem_addr;
                        data_in       <= dmem_wr ? dmem_wdata : '0;
                        en_ext_mem_re <= !dmem_wr;
                        en_ext_mem_wr <= dmem_wr;
                        if (imem_req) begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                    end else if (imem_turn) begin
                        state         <= IMEM;
                        owner         <= REQ_IMEM;
                        imem_gnt      <= 1'b1;
                        mem_addr      <= imem_addr;
                        data_in       <= '0;
                        en_ext_mem_re <= 1'b1;
                        en_ext_mem_wr <= 1'b0;
                        starve_cnt    <= '0;
                    end
                end
                DMEM, IMEM: begin
                    // mem_ready takes precedence over a coincident timeout
                    if (mem_ready || tmo_term) begin
                        if (mem_ready && en_ext_mem_re) begin
                            rdata <= data_out;
                        end
                        err           <= !mem_ready;
                        dmem_ack      <= (owner == REQ_DMEM);
                        imem_ack      <= (owner == REQ_IMEM);
                        dmem_gnt      <= 1'b0;
                        imem_gnt      <= 1'b0;
                        en_ext_mem_re <= 1'b0;
                        en_ext_mem_wr <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

    localparam int WS  = 32;
    localparam int TMO = 8;
    localparam int SL  = 4;

    logic          clk;
    logic          rst;
    logic          dmem_req;
    logic          dmem_wr;
    logic [31:0]   dmem_addr;
    logic [WS-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_ack;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_gnt;
    logic          imem_ack;
    logic          err;
    logic [WS-1:0] rdata;
    logic [31:0]   mem_addr;
    logic [WS-1:0] data_in;
    logic          en_ext_mem_re;
    logic          en_ext_mem_wr;
    logic [WS-1:0] data_out;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .WORD_SIZE    (WS),
        .TIMEOUT      (TMO),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dmem_req      (dmem_req),
        .dmem_wr       (dmem_wr),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_ack      (dmem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_ack      (imem_ack),
        .err           (err),
        .rdata         (rdata),
        .mem_addr      (mem_addr),
        .data_in       (data_in),
        .en_ext_mem_re (en_ext_mem_re),
        .en_ext_mem_wr (en_ext_mem_wr),
        .data_out      (data_out),
        .mem_ready     (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    wire [102:0] dut_vec = {dmem_gnt, dmem_ack, imem_gnt, imem_ack, err,
                            en_ext_mem_re, en_ext_mem_wr, rdata, mem_addr, data_in};

    function automatic logic [102:0] ev(input bit dg, input bit da, input bit ig, input bit ia,
                                        input bit er, input bit re, input bit we,
                                        input logic [31:0] rd, input logic [31:0] ad,
                                        input logic [31:0] di);
        return {dg, da, ig, ia, er, re, we, rd, ad, di};
    endfunction

    // Behavioural model: one pending transaction at most, counted in busy edges
    bit          m_busy;
    int          m_who;
    int          m_edges;
    int          m_streak;
    bit          m_wr;
    bit          m_dg, m_da, m_ig, m_ia, m_err, m_re, m_we;
    logic [31:0] m_rdata, m_addr, m_din;

    task automatic model_edge();
        bit imem_turn;
        if (!rst) begin
            m_busy = 0; m_edges = 0; m_streak = 0; m_wr = 0;
            m_dg = 0; m_da = 0; m_ig = 0; m_ia = 0; m_err = 0; m_re = 0; m_we = 0;
            m_rdata = 0; m_addr = 0; m_din = 0;
        end else begin
            m_da = 0; m_ia = 0; m_err = 0;
            if (!m_busy) begin
                imem_turn = imem_req && (!dmem_req || m_streak >= SL);
                if (dmem_req && !imem_turn) begin
                    m_busy = 1; m_who = 0; m_edges = 0; m_wr = dmem_wr;
                    m_dg = 1; m_addr = dmem_addr; m_din = dmem_wr ? dmem_wdata : 32'h0;
                    m_re = !dmem_wr; m_we = dmem_wr;
                    if (imem_req) m_streak = (m_streak + 1 > SL) ? SL : m_streak + 1;
                end else if (imem_turn) begin
                    m_busy = 1; m_who = 1; m_edges = 0; m_wr = 0;
                    m_ig = 1; m_addr = imem_addr; m_din = 32'h0; m_re = 1; m_we = 0;
                    m_streak = 0;
                end
            end else begin
                m_edges++;
                if (mem_ready || m_edges >= TMO) begin
                    if (mem_ready && !m_wr) m_rdata = data_out;
                    m_err = !mem_ready;
                    if (m_who == 0) m_da = 1; else m_ia = 1;
                    m_busy = 0; m_dg = 0; m_ig = 0; m_re = 0; m_we = 0;
                end
            end
        end
    endtask

    function automatic logic [102:0] model_vec();
        return ev(m_dg, m_da, m_ig, m_ia, m_err, m_re, m_we, m_rdata, m_addr, m_din);
    endfunction

    task automatic apply_stimulus(input logic r, input logic dq, input logic dw,
                                  input logic [31:0] da, input logic [31:0] dd,
                                  input logic iq, input logic [31:0] ia,
                                  input logic rd, input logic [31:0] dout);
        rst = r; dmem_req = dq; dmem_wr = dw; dmem_addr = da; dmem_wdata = dd;
        imem_req = iq; imem_addr = ia; mem_ready = rd; data_out = dout;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_output(input string name, input logic [102:0] exp);
        checks++;
        if (dut_vec !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, dut_vec, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r, dq, dw;
        logic [31:0] da, dd;
        logic        iq;
        logic [31:0] ia;
        logic        rd;
        logic [31:0] dout;
        logic [102:0] exp;
    } vec_t;

    vec_t  tbl[11];
    string order;
    logic  dq, dw, iq, rdy, rr;
    logic [31:0] da, dd, ia, dout;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    ev(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0)};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    ev(1,0,0,0,0,1,0, 32'h0, 32'h100, 32'h0)};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    ev(1,0,0,0,0,1,0, 32'h0, 32'h100, 32'h0)};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    ev(1,0,0,0,0,1,0, 32'h0, 32'h100, 32'h0)};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF,
                    ev(0,1,0,0,0,0,0, 32'hDEADBEEF, 32'h100, 32'h0)};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    ev(0,0,0,0,0,0,0, 32'hDEADBEEF, 32'h100, 32'h0)};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0,
                    ev(1,0,0,0,0,0,1, 32'hDEADBEEF, 32'h10, 32'h12345678)};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D,
                    ev(0,1,0,0,0,0,0, 32'hDEADBEEF, 32'h10, 32'h12345678)};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2000, 1'b0, 32'h0,
                    ev(0,0,1,0,0,1,0, 32'hDEADBEEF, 32'h2000, 32'h0)};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2000, 1'b1, 32'h0BADC0DE,
                    ev(0,0,0,1,0,0,0, 32'h0BADC0DE, 32'h2000, 32'h0)};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    ev(0,0,0,0,0,0,0, 32'h0BADC0DE, 32'h2000, 32'h0)};

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(tbl[i].r, tbl[i].dq, tbl[i].dw, tbl[i].da, tbl[i].dd,
                           tbl[i].iq, tbl[i].ia, tbl[i].rd, tbl[i].dout);
            cycle();
            check_output($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Starvation guard: both requesters held, memory always ready
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        apply_stimulus(1, 1, 0, 32'h40, 0, 1, 32'h80, 1, 32'h5555AAAA);
        order = "";
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (dmem_gnt) order = {order, "D"};
            if (imem_gnt) order = {order, "I"};
            check_bit($sformatf("grant_slot%0d", k), dmem_gnt | imem_gnt, (k % 2 == 0));
        end
        checks++;
        if (order != "DDDDIDDDDI") begin
            errors++;
            $display("[TB] FAIL starve_order: got %s expected DDDDIDDDDI", order);
        end
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // imem timeout: mem_ready never comes
        apply_stimulus(1, 0, 0, 0, 0, 1, 32'h300, 0, 32'h11111111);
        cycle();
        check_output("tmo_grant", ev(0,0,1,0,0,1,0, 32'h5555AAAA, 32'h300, 32'h0));
        for (int k = 1; k < TMO; k++) begin
            cycle();
            check_output($sformatf("tmo_wait%0d", k), ev(0,0,1,0,0,1,0, 32'h5555AAAA, 32'h300, 32'h0));
        end
        cycle();
        check_output("tmo_ack", ev(0,0,0,1,1,0,0, 32'h5555AAAA, 32'h300, 32'h0));
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_output("tmo_idle", ev(0,0,0,0,0,0,0, 32'h5555AAAA, 32'h300, 32'h0));
        apply_stimulus(1, 1, 0, 32'h400, 0, 0, 0, 1, 32'h600DF00D);
        cycle();
        check_output("post_tmo_grant", ev(1,0,0,0,0,1,0, 32'h5555AAAA, 32'h400, 32'h0));
        cycle();
        check_output("post_tmo_ack", ev(0,1,0,0,0,0,0, 32'h600DF00D, 32'h400, 32'h0));
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // mem_ready on the very edge the timeout would fire
        apply_stimulus(1, 0, 0, 0, 0, 1, 32'h500, 0, 0);
        cycle();
        for (int k = 1; k < TMO; k++) cycle();
        apply_stimulus(1, 0, 0, 0, 0, 1, 32'h500, 1, 32'h77778888);
        cycle();
        check_output("ready_vs_tmo", ev(0,0,0,1,0,0,0, 32'h77778888, 32'h500, 32'h0));
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Reset in the middle of a dmem read
        apply_stimulus(1, 1, 0, 32'h600, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        apply_stimulus(0, 1, 0, 32'h600, 0, 0, 0, 1, 32'h99);
        cycle();
        check_output("mid_reset", ev(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0));
        apply_stimulus(1, 1, 0, 32'h600, 0, 0, 0, 0, 0);
        cycle();
        check_output("reissue_grant", ev(1,0,0,0,0,1,0, 32'h0, 32'h600, 32'h0));
        apply_stimulus(1, 1, 0, 32'h600, 0, 0, 0, 1, 32'hABCD0123);
        cycle();
        check_output("reissue_ack", ev(0,1,0,0,0,0,0, 32'hABCD0123, 32'h600, 32'h0));

        // Randomized traffic against the model
        dq = 1; dw = 0; da = 32'h600; dd = 0; iq = 0; ia = 0;
        for (int n = 0; n < 2000; n++) begin
            rr = ($urandom_range(299) != 0);
            if (dq) begin
                if (m_da || $urandom_range(40) == 0) dq = 0;
            end else if ($urandom_range(2) == 0) begin
                dq = 1; dw = 1'($urandom_range(1)); da = $urandom; dd = $urandom;
            end
            if (iq) begin
                if (m_ia || $urandom_range(40) == 0) iq = 0;
            end else if ($urandom_range(2) == 0) begin
                iq = 1; ia = $urandom;
            end
            rdy  = ($urandom_range(9) < 3);
            dout = $urandom;
            apply_stimulus(rr, dq, dw, da, dd, iq, ia, rdy, dout);
            cycle();
            check_output($sformatf("random%0d", n), model_vec());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
